// File: rtl/masked_and_pipe.sv
// Two-stage HPC2 masked AND gadget with valid/ready on both sides; share products go through bin_AND.
// Build option: define MASKED_AND_ZEROIZE_EN to clear a stage's data registers when it drains.
module masked_and_pipe #(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [d-1:0]           ina,
  input  logic [d-1:0]           inb,
  input  logic [d*(d-1)/2-1:0]   rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [d-1:0]           out
);

  localparam int NU = d * (d - 1);

  logic          v1_q, v1_d, v2_q, v2_d;
  logic          adv1, adv2;
  logic [d-1:0]  p_q, p_d, a_q, a_d, out_q, out_d;
  logic [NU-1:0] u_q, u_d, v_q, v_d;
  logic [d-1:0]  na, p_new, c_new;
  logic [NU-1:0] u_new, v_new, t;

  assign na = ~ina;

  // Cross terms for share i are packed at i*(d-1)+k, with k walking j != i in ascending order.
  for (genvar i = 0; i < d; i++) begin : g_row
    bin_AND u_p (.a(ina[i]), .b(inb[i]), .y(p_new[i]));
    for (genvar j = 0; j < d; j++) begin : g_col
      if (j != i) begin : g_pair
        localparam int K  = i * (d - 1) + ((j < i) ? j : j - 1);
        localparam int LO = (i < j) ? i : j;
        localparam int HI = (i < j) ? j : i;
        localparam int R  = LO * d - LO * (LO + 1) / 2 + (HI - LO - 1);
        assign u_new[K] = inb[j] ^ rnd[R];
        bin_AND u_v (.a(na[i]),  .b(rnd[R]), .y(v_new[K]));
        bin_AND u_t (.a(a_q[i]), .b(u_q[K]), .y(t[K]));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < d; i++) begin
      c_new[i] = p_q[i];
      for (int k = 0; k < d - 1; k++) begin
        c_new[i] = c_new[i] ^ v_q[i*(d-1)+k] ^ t[i*(d-1)+k];
      end
    end
  end

  assign adv2     = v1_q && (!v2_q || out_ready);
  assign in_ready = !rst && (!v1_q || adv2);
  assign adv1     = in_valid && in_ready;

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch leaves it unassigned and no latch is inferred.
    v2_d  = adv2 | (v2_q & ~out_ready);
    v1_d  = adv1 | (v1_q & ~adv2);
    p_d   = p_q;
    a_d   = a_q;
    u_d   = u_q;
    v_d   = v_q;
    out_d = out_q;
    if (adv1) begin
      p_d = p_new;
      a_d = ina;
      u_d = u_new;
      v_d = v_new;
    end
`ifdef MASKED_AND_ZEROIZE_EN
    else if (v1_q && !v1_d) begin
      p_d = '0;
      a_d = '0;
      u_d = '0;
      v_d = '0;
    end
`endif
    if (adv2) begin
      out_d = c_new;
    end
`ifdef MASKED_AND_ZEROIZE_EN
    else if (v2_q && !v2_d) begin
      out_d = '0;
    end
`endif
  end

  // NOTE: data registers are reset too, so no share value from before reset can leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      p_q   <= '0;
      a_q   <= '0;
      u_q   <= '0;
      v_q   <= '0;
      out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      p_q   <= p_d;
      a_q   <= a_d;
      u_q   <= u_d;
      v_q   <= v_d;
      out_q <= out_d;
    end
  end

  assign out_valid = v2_q;
  assign out       = out_q;

endmodule

// Single-bit AND kept as its own cell so synthesis cannot merge shares across it.
module bin_AND (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: tb/tb_masked_and_pipe.sv
// Directed and streamed checks of masked_and_pipe for d=2 and d=3.
module tb_masked_and_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0] ina2, inb2, out2;
  logic [0:0] rnd2;

  logic       in_valid3, in_ready3, out_valid3, out_ready3;
  logic [2:0] ina3, inb3, out3, rnd3;

  int n_checks = 0;
  int n_fail   = 0;
  bit q2[$];
  bit q3[$];

  masked_and_pipe #(.d(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .ina(ina2), .inb(inb2), .rnd(rnd2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out(out2)
  );

  masked_and_pipe #(.d(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .ina(ina3), .inb(inb3), .rnd(rnd3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out(out3)
  );

  // Called at a negedge: drive, observe the handshake, return at the next negedge.
  task automatic step2(input logic iv, input logic [1:0] a, input logic [1:0] b,
                       input logic r, input logic ordy, output logic acc,
                       output logic ov, output logic emit, output logic [1:0] o);
    in_valid2 = iv; ina2 = a; inb2 = b; rnd2 = r; out_ready2 = ordy;
    #1;
    acc  = iv && in_ready2;
    ov   = out_valid2;
    emit = out_valid2 && ordy;
    o    = out2;
    @(negedge clk);
  endtask

  task automatic step3(input logic iv, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] r, input logic ordy, output logic acc,
                       output logic emit, output logic [2:0] o);
    in_valid3 = iv; ina3 = a; inb3 = b; rnd3 = r; out_ready3 = ordy;
    #1;
    acc  = iv && in_ready3;
    emit = out_valid3 && ordy;
    o    = out3;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid2 = 0; ina2 = 0; inb2 = 0; rnd2 = 0; out_ready2 = 0;
    in_valid3 = 0; ina3 = 0; inb3 = 0; rnd3 = 0; out_ready3 = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready2); end
    n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid2); end
    n_checks++; if (out2 !== 2'b00) begin n_fail++; $display("FAIL reset_out got=%b exp=00", out2); end
    n_checks++; if (out_valid3 !== 1'b0 || out3 !== 3'b000) begin n_fail++; $display("FAIL reset_d3 got v=%b out=%b exp v=0 out=000", out_valid3, out3); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready2); end
    n_checks++; if (in_ready3 !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready_d3 got=%b exp=1", in_ready3); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic acc, ov, emit;
    logic [1:0] o;
    step2(1, 2'b10, 2'b01, 1'b1, 1, acc, ov, emit, o);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept got=%b exp=1", acc); end
    step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 out_valid got=%b exp=0", ov); end
    step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
    n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL basic_latency2 out_valid got=%b exp=1", ov); end
    n_checks++; if (o !== 2'b01) begin n_fail++; $display("FAIL basic_out got=%b exp=01", o); end
    step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_drained out_valid got=%b exp=0", ov); end
  endtask

  task automatic test_zeroize;
`ifdef MASKED_AND_ZEROIZE_EN
    n_checks++; if (out2 !== 2'b00) begin n_fail++; $display("FAIL zeroize_out got=%b exp=00", out2); end
    n_checks++;
    if (dut2.p_q !== 2'b00 || dut2.a_q !== 2'b00 || dut2.u_q !== 2'b00 || dut2.v_q !== 2'b00) begin
      n_fail++;
      $display("FAIL zeroize_stage1 got p=%b a=%b u=%b v=%b exp all 0", dut2.p_q, dut2.a_q, dut2.u_q, dut2.v_q);
    end
`else
    n_checks++; if (out2 !== 2'b01) begin n_fail++; $display("FAIL stale_out_hold got=%b exp=01", out2); end
`endif
  endtask

  task automatic test_exhaustive_d2;
    logic acc, ov, emit;
    logic [1:0] o;
    logic [3:0] v;
    int sent = 0;
    int got  = 0;
    bit exp;
    for (int c = 0; c < 20; c++) begin
      v = sent[3:0];
      step2(sent < 16, v[1:0], v[3:2], 1'($urandom_range(0, 1)), 1, acc, ov, emit, o);
      if (sent < 16) begin
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL exh2_accept item=%0d got=%b exp=1", sent, acc); end
      end
      if (acc) begin q2.push_back((^v[1:0]) & (^v[3:2])); sent++; end
      n_checks++;
      if (emit !== (c >= 2 && c < 18)) begin n_fail++; $display("FAIL exh2_throughput cycle=%0d got=%b exp=%b", c, emit, (c >= 2 && c < 18)); end
      if (emit) begin
        exp = (q2.size() > 0) ? q2.pop_front() : 1'bx;
        n_checks++; if ((^o) !== exp) begin n_fail++; $display("FAIL exh2_result idx=%0d got=%b exp=%b", got, ^o, exp); end
        got++;
      end
    end
    n_checks++; if (got !== 16) begin n_fail++; $display("FAIL exh2_count got=%0d exp=16", got); end
  endtask

  task automatic test_exhaustive_d3;
    logic acc, emit;
    logic [2:0] o;
    logic [5:0] v;
    int sent = 0;
    int got  = 0;
    bit exp;
    for (int c = 0; c < 68; c++) begin
      v = sent[5:0];
      step3(sent < 64, v[2:0], v[5:3], 3'($urandom_range(0, 7)), 1, acc, emit, o);
      if (sent < 64) begin
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL exh3_accept item=%0d got=%b exp=1", sent, acc); end
      end
      if (acc) begin q3.push_back((^v[2:0]) & (^v[5:3])); sent++; end
      n_checks++;
      if (emit !== (c >= 2 && c < 66)) begin n_fail++; $display("FAIL exh3_throughput cycle=%0d got=%b exp=%b", c, emit, (c >= 2 && c < 66)); end
      if (emit) begin
        exp = (q3.size() > 0) ? q3.pop_front() : 1'bx;
        n_checks++; if ((^o) !== exp) begin n_fail++; $display("FAIL exh3_result idx=%0d got=%b exp=%b", got, ^o, exp); end
        got++;
      end
    end
    n_checks++; if (got !== 64) begin n_fail++; $display("FAIL exh3_count got=%0d exp=64", got); end
  endtask

  task automatic test_backpressure;
    logic [1:0] ta [5];
    logic [1:0] tb_[5];
    bit exp [5];
    logic acc, ov, emit, have;
    logic [1:0] o, held;
    int idx = 0;
    int got = 0;
    int k;
    ta  = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
    tb_ = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
    exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    have = 1'b0;
    held = 2'b00;
    for (int c = 0; c < 6; c++) begin
      step2(1, ta[idx], tb_[idx], 1'(c), 0, acc, ov, emit, o);
      if (acc) idx++;
      if (out_valid2 && !have) begin
        have = 1'b1; held = out2;
      end else if (out_valid2) begin
        n_checks++; if (out2 !== held) begin n_fail++; $display("FAIL bp_out_hold cycle=%0d got=%b exp=%b", c, out2, held); end
      end
    end
    n_checks++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
    #1;
    n_checks++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready2); end
    n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%b exp=1", out_valid2); end
    @(negedge clk);
    for (int c = 0; c < 20 && got < 5; c++) begin
      k = (idx < 5) ? idx : 0;
      step2(idx < 5, ta[k], tb_[k], 1'b1, 1, acc, ov, emit, o);
      if (acc) idx++;
      if (emit) begin
        n_checks++; if ((^o) !== exp[got]) begin n_fail++; $display("FAIL bp_drain idx=%0d got=%b exp=%b", got, ^o, exp[got]); end
        got++;
      end
    end
    n_checks++; if (got !== 5 || idx !== 5) begin n_fail++; $display("FAIL bp_count got=%0d/%0d exp=5/5", got, idx); end
    step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate out_valid got=%b exp=0", ov); end
  endtask

  task automatic test_random;
    logic acc, ov, emit, iv, ordy, prev_stall;
    logic [1:0] a, b, o, prev_out;
    logic r;
    bit exp;
    prev_stall = 1'b0;
    prev_out   = 2'b00;
    for (int c = 0; c < 10000; c++) begin
      if (prev_stall) begin
        n_checks++;
        if (out_valid2 !== 1'b1 || out2 !== prev_out) begin
          n_fail++; $display("FAIL rnd_stall cycle=%0d got v=%b out=%b exp v=1 out=%b", c, out_valid2, out2, prev_out);
        end
      end
      iv = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3)); r = 1'($urandom_range(0, 1));
      step2(iv, a, b, r, ordy, acc, ov, emit, o);
      if (acc) q2.push_back((^a) & (^b));
      if (emit) begin
        exp = (q2.size() > 0) ? q2.pop_front() : 1'bx;
        n_checks++; if ((^o) !== exp) begin n_fail++; $display("FAIL rnd_result cycle=%0d got=%b exp=%b", c, ^o, exp); end
      end
      prev_stall = ov && !ordy;
      prev_out   = o;
    end
    for (int c = 0; c < 10 && q2.size() > 0; c++) begin
      step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
      if (emit) begin
        exp = q2.pop_front();
        n_checks++; if ((^o) !== exp) begin n_fail++; $display("FAIL rnd_drain got=%b exp=%b", ^o, exp); end
      end
    end
    n_checks++; if (q2.size() !== 0) begin n_fail++; $display("FAIL rnd_leftover got=%0d exp=0", q2.size()); end
  endtask

  task automatic test_reset_midflight;
    logic acc, ov, emit;
    logic [1:0] o;
    step2(1, 2'b10, 2'b01, 1'b1, 0, acc, ov, emit, o);
    step2(1, 2'b01, 2'b01, 1'b0, 0, acc, ov, emit, o);
    n_checks++;
    if (out_valid2 !== 1'b1 || out2 !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_full got v=%b out=%b exp v=1 out=01", out_valid2, out2);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid2); end
    n_checks++; if (out2 !== 2'b00) begin n_fail++; $display("FAIL rstmid_out got=%b exp=00", out2); end
    n_checks++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready2); end
    @(negedge clk);
    rst = 1'b0;
    q2.delete();
    step2(1, 2'b10, 2'b01, 1'b1, 1, acc, ov, emit, o);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept got=%b exp=1", acc); end
    step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_latency1 got=%b exp=0", ov); end
    step2(0, 2'b00, 2'b00, 1'b0, 1, acc, ov, emit, o);
    n_checks++;
    if (ov !== 1'b1 || o !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_result got v=%b out=%b exp v=1 out=01", ov, o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zeroize;
    test_exhaustive_d2;
    test_exhaustive_d3;
    test_backpressure;
    test_random;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
